// File: rtl/if_id_frontend.sv
// rtl/if_id_frontend.sv - MIPS fetch PC, next-PC selection, jr forwarding/hazard and IF/ID register
module if_id_frontend #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction,
    output logic [31:0] PC,
    input  logic [1:0]  ID_rs_Src,
    input  logic [31:0] RF_rs_data,
    input  logic [31:0] EX_ALUOut,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] WB_data,
    input  logic        ID_Jump,
    input  logic        ID_JumpReg,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rd,
    input  logic        MEM_MemRead,
    input  logic [4:0]  MEM_rd,
    input  logic        Hazard_stall,
    input  logic        EX_Branch_taken,
    input  logic [31:0] EX_Branch_target,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PC_plus4,
    output logic [4:0]  ID_rs,
    output logic [31:0] ID_rs_fwd,
    output logic        ID_Flush
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pc_plus4;
    logic [31:0] j_target;
    logic        jr_stall;
    logic        stall;

    assign PC               = pc_q;
    assign IFID_Instruction = instr_q;
    assign IFID_PC_plus4    = pc4_q;
    assign ID_rs            = instr_q[25:21];
    assign pc_plus4         = pc_q + 32'd4;
    assign j_target         = {pc4_q[31:28], instr_q[25:0], 2'b00};

    always_comb begin
        unique case (ID_rs_Src)
            2'b11:   ID_rs_fwd = EX_ALUOut;
            2'b10:   ID_rs_fwd = MEM_ALUOut;
            2'b01:   ID_rs_fwd = WB_data;
            default: ID_rs_fwd = RF_rs_data;
        endcase
    end

    // jr reads rs in ID, so a pending load in EX or MEM cannot be forwarded yet
    assign jr_stall = ID_JumpReg &&
                      ((EX_MemRead  && (EX_rd  != 5'd0) && (EX_rd  == ID_rs)) ||
                       (MEM_MemRead && (MEM_rd != 5'd0) && (MEM_rd == ID_rs)));
    assign stall    = Hazard_stall | jr_stall;
    assign ID_Flush = EX_Branch_taken | stall;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (EX_Branch_taken) begin
            pc_d    = EX_Branch_target;
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
        end else if (!stall) begin
            if (ID_JumpReg) begin
                pc_d    = ID_rs_fwd;
                instr_d = NOP_INSTR;
                pc4_d   = 32'd0;
            end else if (ID_Jump) begin
                pc_d    = j_target;
                instr_d = NOP_INSTR;
                pc4_d   = 32'd0;
            end else begin
                pc_d    = pc_plus4;
                instr_d = Instruction;
                pc4_d   = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

endmodule

// File: doc/if_id_frontend.md
Name: if_id_frontend

Overview:
- Instruction-fetch front end and IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the PC and selects the next PC from sequential, ID-stage jumps (j/jal/jr) and EX-stage taken branches.
- Consumes the 2-bit ID rs-source select from the ID forwarding unit and muxes the forwarded rs value used as the jr target.
- Detects jr load-use hazards and drives stall/flush toward the ID/EX register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush

Ports:
clk  input  1  pipeline clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
Instruction  input  32  instruction memory read data for current PC (combinational ROM)
PC  output  32  current fetch address to instruction memory
ID_rs_Src  input  2  rs source select from ID forwarding: 00 regfile, 01 WB, 10 MEM, 11 EX
RF_rs_data  input  32  register-file read data for ID rs
EX_ALUOut  input  32  EX-stage result
MEM_ALUOut  input  32  MEM-stage ALU result
WB_data  input  32  WB-stage write data
ID_Jump  input  1  decoded j/jal in ID
ID_JumpReg  input  1  decoded jr/jalr in ID
EX_MemRead  input  1  EX-stage instruction is a load
EX_rd  input  5  EX-stage destination register
MEM_MemRead  input  1  MEM-stage instruction is a load
MEM_rd  input  5  MEM-stage destination register
Hazard_stall  input  1  external load-use stall request (non-jr)
EX_Branch_taken  input  1  EX-stage branch resolved taken
EX_Branch_target  input  32  EX-stage branch target
IFID_Instruction  output  32  registered instruction in ID
IFID_PC_plus4  output  32  registered PC+4 of the ID instruction
ID_rs  output  5  IFID_Instruction[25:21], to the forwarding unit
ID_rs_fwd  output  32  forwarded rs value
ID_Flush  output  1  insert bubble into ID/EX this cycle

Behaviour:
- Reset (async, active-high):
  - PC=RESET_PC.
  - IFID_Instruction=NOP_INSTR; IFID_PC_plus4=0.
  - Combinational outputs follow from these values.
- ID_rs_fwd (combinational): 11→EX_ALUOut, 10→MEM_ALUOut, 01→WB_data, 00→RF_rs_data.
- jr_stall = ID_JumpReg && ((EX_MemRead && EX_rd!=0 && EX_rd==ID_rs) || (MEM_MemRead && MEM_rd!=0 && MEM_rd==ID_rs)).
  - A load in EX followed by jr costs 2 stall cycles; a load in MEM costs 1.
- stall = Hazard_stall | jr_stall.
- Targets:
  - j_target = {IFID_PC_plus4[31:28], IFID_Instruction[25:0], 2'b00}.
  - jr_target = ID_rs_fwd, used unmodified; no alignment check.
- Next-state priority at each rising edge (highest first):
  1. EX_Branch_taken: PC←EX_Branch_target; IF/ID←{NOP_INSTR, 0}. Overrides stall and any ID jump.
  2. stall: PC and IF/ID hold.
  3. ID_JumpReg: PC←jr_target; IF/ID←{NOP_INSTR, 0}. No delay slot.
  4. ID_Jump: PC←j_target; IF/ID←{NOP_INSTR, 0}.
  5. Otherwise: PC←PC+4; IF/ID←{Instruction, PC+4}.
- If ID_Jump and ID_JumpReg are both asserted, jr wins.
- ID_Flush = EX_Branch_taken | stall (combinational). When a jump redirects, the jump itself proceeds into EX (jal must write $ra).
- PC+4 wraps modulo 2^32: 32'hFFFF_FFFC → 0.
- Reset asserted mid-stall or mid-redirect: the state returns to reset values immediately. On the first edge after reset deasserts, the front end fetches RESET_PC+4 with no stall carried over.

Test Plan:
- Reset, then 3 clocks with no controls asserted → PC sequence RESET_PC, +4, +8, +12; IFID_PC_plus4 = PC_prev+4; IFID_Instruction matches the ROM word.
- j in ID with IFID_PC_plus4=32'h0040_0010, instr[25:0]=26'h0000_040 → next PC = 32'h0000_0100; IFID_Instruction=NOP_INSTR; ID_Flush=0.
- jr with ID_rs_Src=11, EX_ALUOut=32'h0000_2000 → next PC = 32'h0000_2000. Repeat with select 10/01/00 → MEM_ALUOut / WB_data / RF_rs_data used.
- lw $8 in EX, jr $8 in ID (EX_MemRead=1, EX_rd=8) → PC holds 2 cycles (second cycle via MEM_MemRead), ID_Flush=1 each cycle. With EX_rd=0, no stall.
- EX_Branch_taken=1 together with Hazard_stall=1 and ID_Jump=1, target 32'h0000_0080 → PC=32'h0000_0080; IF/ID flushed; ID_Flush=1.
- PC=32'hFFFF_FFFC, sequential fetch → PC=0. Assert reset mid-stall → PC=RESET_PC asynchronously, before the next edge.
